// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter with bounded hold in front of a single-port on-chip RAM; reads are tagged by owner.
// Optional build macro ONCHIP_RAM_ARB_PERF_EN adds accept/contention counters.
module onchip_ram_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int NUM_WORDS = 25600,
  parameter int MAX_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata
`ifdef ONCHIP_RAM_ARB_PERF_EN
  ,
  output logic [31:0]       m0_grant_cnt,
  output logic [31:0]       m1_grant_cnt,
  output logic [31:0]       contend_cnt
`endif
);

  localparam logic [3:0]      MAX_HOLD_C = 4'(MAX_HOLD);
  localparam logic [ADDR_W:0] LIMIT      = (ADDR_W+1)'(NUM_WORDS);

  logic              req0, req1;
  logic              grant0, grant1;
  logic              keep;
  logic              accepted;
  logic              sel_write, sel_read;
  logic              in_range;
  logic [ADDR_W-1:0] sel_address;

  logic              last_owner;
  logic [3:0]        hold_cnt;
  logic              rd_pend, rd_owner, rd_oor;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // A zero hold count means no run is in progress, so a tie goes to the
  // requester that did not own the bus last (m0 after reset).
  assign keep = (hold_cnt != 4'd0) && (hold_cnt < MAX_HOLD_C);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (keep ^ (last_owner == 1'b0)) grant1 = 1'b1;
        else                             grant0 = 1'b1;
      end else if (req0) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accepted    = grant0 | grant1;
  assign sel_address = grant1 ? m1_address : m0_address;
  assign sel_write   = grant1 ? m1_write   : m0_write;
  assign sel_read    = (grant1 ? m1_read : m0_read) & ~sel_write;
  assign in_range    = {1'b0, sel_address} < LIMIT;

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  assign ram_address    = sel_address;
  assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign ram_chipselect = accepted & in_range;
  assign ram_write      = accepted & sel_write;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b1;
      hold_cnt   <= 4'd0;
    end else if (accepted) begin
      last_owner <= grant1;
      if (grant1 == last_owner) begin
        if (hold_cnt != 4'hF) hold_cnt <= hold_cnt + 4'd1;
      end else begin
        hold_cnt <= 4'd1;
      end
    end else if (!req0 && !req1) begin
      hold_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_pend  <= accepted & sel_read;
      rd_owner <= grant1;
      rd_oor   <= ~in_range;
    end
  end

  // Gating with reset keeps a read accepted just before reset from pulsing.
  assign m0_readdatavalid = rd_pend & ~reset & ~rd_owner;
  assign m1_readdatavalid = rd_pend & ~reset &  rd_owner;
  assign m0_readdata      = (m0_readdatavalid & ~rd_oor) ? ram_readdata : 32'h0;
  assign m1_readdata      = (m1_readdatavalid & ~rd_oor) ? ram_readdata : 32'h0;

`ifdef ONCHIP_RAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_grant_cnt <= 32'd0;
      m1_grant_cnt <= 32'd0;
      contend_cnt  <= 32'd0;
    end else begin
      if (grant0)        m0_grant_cnt <= m0_grant_cnt + 32'd1;
      if (grant1)        m1_grant_cnt <= m1_grant_cnt + 32'd1;
      if (req0 && req1)  contend_cnt  <= contend_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Scoreboarded bench for onchip_ram_arbiter with a behavioural 1-cycle RAM.
module tb_onchip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
`ifdef ONCHIP_RAM_ARB_PERF_EN
  logic [31:0] m0_grant_cnt, m1_grant_cnt, contend_cnt;
`endif

  always #5 clk = ~clk;

  onchip_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
`ifdef ONCHIP_RAM_ARB_PERF_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .contend_cnt(contend_cnt)
`endif
  );

  // RAM model: address registered every clock, q combinational from it
  logic [31:0] mem [0:25599];
  logic [14:0] addr_q;
  always @(posedge clk) begin
    if (ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
    addr_q <= ram_address;
  end
  assign ram_readdata = (addr_q < 15'd25600) ? mem[addr_q] : 32'hFFFF_FFFF;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int n_cmp = 0, n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected read responses whenever a readdatavalid shows up
  always @(negedge clk) begin
    if (m0_readdatavalid === 1'b1) begin
      if (q0.size() == 0) chk("m0 spurious readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("m0 readdata", m0_readdata, e0.d);
        chk("m0 read latency cycle", cyc, e0.c);
        chk("m1 readdata while m0 owns", m1_readdata, 32'h0);
      end
    end
    if (m1_readdatavalid === 1'b1) begin
      if (q1.size() == 0) chk("m1 spurious readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("m1 readdata", m1_readdata, e1.d);
        chk("m1 read latency cycle", cyc, e1.c);
        chk("m0 readdata while m1 owns", m0_readdata, 32'h0);
      end
    end
  end

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic push_exp(input bit m, input logic [31:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 1;
    if (m) q1.push_back(e); else q0.push_back(e);
  endtask

  // One single-master command; expected to be accepted in its first cycle
  task automatic cmd(input bit m, input bit rd, input bit wr, input logic [14:0] a,
                     input logic [3:0] be, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_cs);
    clear_inputs();
    if (m) begin m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d; end
    else   begin m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d; end
    @(negedge clk);
    chk(m ? "m1 waitrequest" : "m0 waitrequest", {31'd0, m ? m1_waitrequest : m0_waitrequest}, 32'd0);
    chk("ram_chipselect", {31'd0, ram_chipselect}, {31'd0, exp_cs});
    if (rd && !wr) push_exp(m, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(negedge clk);
    chk("reset m0_readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
    chk("reset m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
    chk("reset ram_chipselect", {31'd0, ram_chipselect}, 32'd0);
    chk("reset m0_waitrequest", {31'd0, m0_waitrequest}, 32'd1);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    bit exp_owner;
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Write then read same address back to back
    cmd(0, 0, 1, 15'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 1);
    cmd(0, 1, 0, 15'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1);
    idle();

    // Byte-lane write from m1
    cmd(1, 0, 1, 15'h0020, 4'hF, 32'h11223344, 32'h0, 1);
    cmd(1, 0, 1, 15'h0020, 4'b0010, 32'h0000AB00, 32'h0, 1);
    cmd(1, 1, 0, 15'h0020, 4'h0, 32'h0, 32'h1122AB44, 1);
    idle();

    // Alternating owners, consecutive reads
    cmd(0, 1, 0, 15'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1);
    cmd(1, 1, 0, 15'h0020, 4'h0, 32'h0, 32'h1122AB44, 1);
    cmd(0, 1, 0, 15'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1);
    idle();

    // Range boundary: last word vs first out-of-range word
    cmd(0, 0, 1, 15'h63FF, 4'hF, 32'hCAFEF00D, 32'h0, 1);
    cmd(0, 0, 1, 15'h6400, 4'hF, 32'h12345678, 32'h0, 0);
    cmd(0, 1, 0, 15'h6400, 4'h0, 32'h0, 32'h0, 0);
    cmd(0, 1, 0, 15'h63FF, 4'h0, 32'h0, 32'hCAFEF00D, 1);
    idle();

    // Continuous contention: m0 x4, m1 x4, ...
    do_reset();
    m0_read = 1; m0_address = 15'h0010;
    m1_read = 1; m1_address = 15'h0020;
    for (int k = 0; k < 16; k++) begin
      exp_owner = ((k / 4) % 2) != 0;
      @(negedge clk);
      chk("stream m0 waitrequest", {31'd0, m0_waitrequest}, {31'd0, exp_owner});
      chk("stream m1 waitrequest", {31'd0, m1_waitrequest}, {31'd0, !exp_owner});
      push_exp(exp_owner, exp_owner ? 32'h1122AB44 : 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    idle();
    idle();

    // Reset right after an accepted m1 read: no pulse now or later
    clear_inputs();
    m1_read = 1; m1_address = 15'h0020;
    @(negedge clk);
    chk("pre-reset m1 waitrequest", {31'd0, m1_waitrequest}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset-mid-read m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
      @(posedge clk); #1;
    end
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-reset m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
      @(posedge clk); #1;
    end

`ifdef ONCHIP_RAM_ARB_PERF_EN
    do_reset();
    m0_write = 1; m0_address = 15'h0030; m0_byteenable = 4'hF; m0_writedata = 32'h1;
    m1_write = 1; m1_address = 15'h0031; m1_byteenable = 4'hF; m1_writedata = 32'h2;
    repeat (10) begin @(posedge clk); #1; end
    idle();
    chk("contend_cnt", contend_cnt, 32'd10);
    chk("m0_grant_cnt", m0_grant_cnt, 32'd6);
    chk("m1_grant_cnt", m1_grant_cnt, 32'd4);
`endif

    idle();
    idle();
    chk("m0 reads outstanding", q0.size(), 32'd0);
    chk("m1 reads outstanding", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
